// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment digit scanner.
// Holds the scan-state enum, the all-anodes-off mask and a nibble selector.
// Purely declarative: no logic, no latency, no backpressure.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } scan_state_t;

  // All anodes released (active-low), sized for the widest legal display.
  function automatic logic [MAX_DIGITS-1:0] anode_off_mask();
    return '1;
  endfunction

  // Nibble k of a value packed four bits per digit.
  function automatic logic [3:0] digit_of(input logic [31:0] v, input logic [2:0] k);
    return v[{k, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter: counts 0..REFRESH_DIV-1 and flags the dead window.
// Latency: flags are combinational from the registered count.
// Backpressure: none; the counter is held at zero whenever run is low.
module seg7_slot_timer #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic dead,
  output logic dead_end,
  output logic slot_end
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_W    = CW'(DEAD_CYCLES);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  // Slot counter: equality wrap at REFRESH_DIV-1, so it never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_end = (cnt == LAST);
  assign dead     = (cnt < DEAD_W);
  assign dead_end = (DEAD_CYCLES > 0) && (cnt == DEAD_LAST);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed hex digit scanner feeding a 7-segment decoder; new values latch at frame starts.
// Latency: bcd/anode/frame_o registered, one cycle after the state decision; load visible within 1 frame + 1 cycle.
// Backpressure: none; optional leading-zero blanking when SEG7_SCAN_LZB_EN is defined.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_i,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_o
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [MAX_DIGITS-1:0] ALL_OFF   = anode_off_mask();
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ALL_OFF[NUM_DIGITS-1:0];
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = NUM_DIGITS'(1);

  scan_state_t           state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [VW-1:0]         pend, disp, disp_nxt;
  logic                  pend_v;
  logic                  run, dead, dead_end, slot_end;
  logic                  slot_adv, frame_start, xfer;
  logic                  blank_nxt;
  logic [3:0]            bcd_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic                  frame_nxt;

  assign run         = en_i && (state != ST_OFF);
  assign slot_adv    = en_i && (state == ST_ON) && slot_end;
  assign frame_start = en_i && ((state == ST_OFF) || (slot_adv && (idx == IDX_LAST)));
  assign xfer        = frame_start && pend_v;
  assign disp_nxt    = xfer ? pend : disp;

  seg7_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .dead     (dead),
    .dead_end (dead_end),
    .slot_end (slot_end)
  );

  // State and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next scan state; dropping en_i aborts the slot from any state.
  always_comb begin
    state_nxt = state;
    if (!en_i) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF:  state_nxt = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;
        // Also leave DEAD if the counter is somehow already past the dead window.
        ST_DEAD: if (dead_end || !dead) state_nxt = ST_ON;
        ST_ON:   if (slot_end && (DEAD_CYCLES != 0)) state_nxt = ST_DEAD;
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  // Digit index: restarts at 0 on enable, explicit wrap for non-power-of-2 counts.
  always_comb begin
    idx_nxt = idx;
    if (!en_i || (state == ST_OFF)) begin
      idx_nxt = '0;
    end else if (slot_adv) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  // Blank digit k>0 when it and every more-significant digit are zero.
  always_comb begin
    blank_nxt = 1'b0;
    if (idx_nxt != '0) begin
      blank_nxt = ((32'(disp_nxt) >> {idx_nxt, 2'b00}) == 32'd0);
    end
  end
`else
  assign blank_nxt = 1'b0;
`endif

  // Output decode from the upcoming state so the registered outputs line up with cnt/idx.
  always_comb begin
    anode_nxt = ANODE_OFF;
    bcd_nxt   = bcd;
    frame_nxt = 1'b0;
    if (en_i) begin
      bcd_nxt   = digit_of(32'(disp_nxt), 3'(idx_nxt));
      frame_nxt = frame_start;
      if ((state_nxt == ST_ON) && !blank_nxt) begin
        anode_nxt = ~(ONE_HOT0 << idx_nxt);
      end
    end
  end

  // Capture buffer (last load wins) and tear-free transfer at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      pend_v <= 1'b0;
      disp   <= '0;
    end else begin
      if (load_i) begin
        pend <= value_i;
      end
      pend_v <= load_i || (pend_v && !xfer);
      disp   <= disp_nxt;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd     <= 4'h0;
      anode   <= ANODE_OFF;
      frame_o <= 1'b0;
    end else begin
      bcd     <= bcd_nxt;
      anode   <= anode_nxt;
      frame_o <= frame_nxt;
    end
  end

endmodule
